// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and default widths.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam int unsigned REG_W_DEF = 5;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Pair of saturating 32-bit event counters; index 0 counts stall cycles, index 1 counts flush cycles.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  inc_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [31:0] cnt_q [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q[gi] <= '0;
        end else if (inc_i[gi] && (cnt_q[gi] != 32'hFFFF_FFFF)) begin
          cnt_q[gi] <= cnt_q[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign stall_cnt_o = cnt_q[0];
  assign flush_cnt_o = cnt_q[1];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > redirect > load-use > run.
// Optional StallCycles/FlushCount performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned REG_W           = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IdRs,
  input  logic [REG_W-1:0] IdRt,
  input  logic             IdUsesRt,
  input  logic             ExMemRead,
  input  logic [REG_W-1:0] ExRt,
  input  logic             ExBranchTaken,
  input  logic             IdJump,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             Hazard,
  output logic             PCWrite,
  output logic             IF_IDFlash,
  output logic             ID_EXFlush,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      StallCycles,
  output logic [31:0]      FlushCount,
`endif
  output logic             EX_MEMStall
);

  localparam logic [1:0] LU_INIT = 2'(LOAD_USE_CYCLES - 1);

  hz_state_e  state_q, state_d;
  hz_state_e  ret_q, ret_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       flush_pend_q, flush_pend_d;
  logic       suppress_q, suppress_d;

  logic       load_use;
  logic       mem_wait;
  logic       redirect;
  hz_state_e  eff_state;

  assign load_use = ExMemRead && (ExRt != '0) &&
                    ((ExRt == IdRs) || (IdUsesRt && (ExRt == IdRt)));
  assign mem_wait = MemReq && !MemReady;
  assign redirect = ExBranchTaken || flush_pend_q;
  // Leaving MEM_WAIT behaves as the saved state within the same cycle.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    lu_cnt_d     = lu_cnt_q;
    flush_pend_d = flush_pend_q;
    suppress_d   = suppress_q;
    Hazard       = 1'b0;
    PCWrite      = 1'b1;
    IF_IDFlash   = 1'b0;
    ID_EXFlush   = 1'b0;
    EX_MEMStall  = 1'b0;

    if (rst) begin
      // Clears the reset-less IF/ID and ID/EX registers while reset is held.
      PCWrite    = 1'b0;
      IF_IDFlash = 1'b1;
      ID_EXFlush = 1'b1;
    end else if (mem_wait) begin
      Hazard       = 1'b1;
      PCWrite      = 1'b0;
      EX_MEMStall  = 1'b1;
      state_d      = MEM_WAIT;
      flush_pend_d = flush_pend_q || ExBranchTaken;
      if (state_q != MEM_WAIT) begin
        ret_d = state_q;
      end
    end else if (redirect) begin
      IF_IDFlash   = 1'b1;
      ID_EXFlush   = 1'b1;
      state_d      = RUN;
      lu_cnt_d     = 2'd0;
      flush_pend_d = 1'b0;
      suppress_d   = 1'b0;
    end else if (eff_state == LU_STALL) begin
      Hazard     = 1'b1;
      PCWrite    = 1'b0;
      ID_EXFlush = 1'b1;
      if (lu_cnt_q <= 2'd1) begin
        state_d    = RUN;
        lu_cnt_d   = 2'd0;
        suppress_d = 1'b1;
      end else begin
        state_d  = LU_STALL;
        lu_cnt_d = lu_cnt_q - 2'd1;
      end
    end else begin
      state_d    = RUN;
      suppress_d = 1'b0;
      if (load_use && !suppress_q) begin
        Hazard     = 1'b1;
        PCWrite    = 1'b0;
        ID_EXFlush = 1'b1;
        if (LOAD_USE_CYCLES > 1) begin
          state_d  = LU_STALL;
          lu_cnt_d = LU_INIT;
        end else begin
          suppress_d = 1'b1;
        end
      end else if (IdJump) begin
        IF_IDFlash = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      ret_q        <= RUN;
      lu_cnt_q     <= 2'd0;
      flush_pend_q <= 1'b0;
      suppress_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      lu_cnt_q     <= lu_cnt_d;
      flush_pend_q <= flush_pend_d;
      suppress_q   <= suppress_d;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .inc_i       ({IF_IDFlash && !rst, Hazard}),
    .stall_cnt_o (StallCycles),
    .flush_cnt_o (FlushCount)
  );
`endif

endmodule
